// File: rtl/registrador_pipeline.sv
// registrador_pipeline: elastic chain of DEPTH valid/ready register stages with flush and occupancy count
module registrador_pipeline #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      v_q, v_d, up_v;
    logic [DEPTH:0]        rdy;
    logic [DATA_WIDTH-1:0] d_q [DEPTH];
    logic [DATA_WIDTH-1:0] d_d [DEPTH];
    logic [DATA_WIDTH-1:0] up_d [DEPTH];

    // readiness ripples back from the consumer; each stage loads from upstream when ready, flush only clears valids
    always_comb begin
        rdy[DEPTH] = ready_i;
        for (int k = DEPTH - 1; k >= 0; k--)
            rdy[k] = ~v_q[k] | rdy[k+1];
        up_v[0] = valid_i;
        up_d[0] = data_i;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = flush_i ? 1'b0 : rdy[k] ? up_v[k] : v_q[k];
            d_d[k] = (!flush_i && rdy[k] && up_v[k]) ? up_d[k] : d_q[k];
        end
    end

    // stage registers, cleared asynchronously so in-flight words are discarded at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++)
                d_q[k] <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    // occupancy is the popcount of the stage valid bits
    always_comb begin
        count_o = '0;
        for (int k = 0; k < DEPTH; k++)
            count_o = count_o + CW'(v_q[k]);
    end

    assign ready_o = rdy[0] & ~flush_i;
    assign valid_o = v_q[DEPTH-1] & ~flush_i;
    assign data_o  = d_q[DEPTH-1];
endmodule

// File: doc/registrador_pipeline.md
REGISTRADOR_PIPELINE -- requirements
Module: registrador_pipeline

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and set the payload width in bits (>=1).
REQ-002 The parameter DEPTH SHALL default to 4 and set the number of register stages (>=1).
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 The port flush_i SHALL be an input, 1 bit wide, and act as a synchronous clear of all stages.
REQ-006 The port valid_i SHALL be an input, 1 bit wide, and indicate that data_i carries a valid word.
REQ-007 The port ready_o SHALL be an output, 1 bit wide, and indicate that the block accepts data_i this cycle.
REQ-008 The port data_i SHALL be an input, DATA_WIDTH bits wide, and carry the input payload.
REQ-009 The port valid_o SHALL be an output, 1 bit wide, and indicate that data_o carries a valid word.
REQ-010 The port ready_i SHALL be an input, 1 bit wide, and indicate that the downstream consumer accepts data_o.
REQ-011 The port data_o SHALL be an output, DATA_WIDTH bits wide, and carry the payload of the last stage.
REQ-012 The port count_o SHALL be an output, $clog2(DEPTH+1) bits wide, and give the number of occupied stages.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold a valid bit v[k] and a data register d[k]; stage 0 is the input side and stage DEPTH-1 drives the outputs.
REQ-014 Stage readiness SHALL be defined as rdy[DEPTH] = ready_i and rdy[k] = ~v[k] | rdy[k+1], which makes it a combinational chain.
REQ-015 When rdy[k]=1, stage k SHALL load v[k] <= v[k-1] on the clock edge, with valid_i used for k=0; when rdy[k]=0, stage k SHALL hold.
REQ-016 d[k] SHALL load from d[k-1] (data_i for k=0) only when rdy[k]=1 and the upstream valid bit is 1; otherwise d[k] SHALL keep its value.
REQ-017 The handshake outputs SHALL be ready_o = rdy[0] & ~flush_i and valid_o = v[DEPTH-1] & ~flush_i.
REQ-018 data_o SHALL equal d[DEPTH-1] at all times.
REQ-019 A transfer SHALL occur only on a cycle where valid and ready are both 1 on the same side.
REQ-020 valid_o, once asserted, SHALL remain 1 with data_o stable until ready_i=1 or flush_i=1.
REQ-021 Latency: a word accepted at edge t with ready_i held 1 SHALL appear with valid_o=1 after edge t+DEPTH-1 (DEPTH=1 gives one-cycle latency).
REQ-022 Throughput SHALL be one word per cycle in steady state when ready_i=1.
REQ-023 Bubbles SHALL collapse: while ready_i=0, an empty stage SHALL accept from its upstream stage.
REQ-024 Full with ready_i=0: all v=1, and ready_o SHALL be 0.
REQ-025 Full with ready_i=1: ready_o SHALL be 1, so that input is accepted and output is drained in the same cycle and count_o is unchanged.
REQ-026 Empty: valid_o SHALL be 0, data_o SHALL hold the last value, and count_o SHALL be 0.
REQ-027 flush_i=1 SHALL clear all v[k] on the next edge; no input SHALL be accepted and no output SHALL be presented that cycle, and d[k] SHALL be unchanged.
REQ-028 flush_i SHALL take priority over every load.
REQ-029 count_o SHALL be the popcount of v[0..DEPTH-1], combinational from registered state.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk, clear all v[k] to 0 and all d[k] to 0.
REQ-031 While reset=0, the outputs SHALL be valid_o=0, data_o=0, count_o=0, and ready_o=1 unless flush_i=1.
REQ-032 Reset asserted mid-transfer SHALL discard all in-flight words, and no partial state SHALL remain after release.
REQ-033 After reset release, the first rising edge SHALL operate normally, with no extra cycles required.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-034 Streaming: with ready_i=1, drive valid_i=1 and data 0x01..0x08 on consecutive cycles -> valid_o rises 3 cycles after the first acceptance, 0x01..0x08 appear in order one per cycle, and count_o peaks at 4.
REQ-035 Fill/stall: with ready_i=0, push 0xA0..0xA5 -> 4 accepted, ready_o=0 with count_o=4, and data_o=0xA0; then ready_i=1 -> 0xA0..0xA3 drain in order.
REQ-036 Full pass-through: while full, drive ready_i=1 and valid_i=1 with data 0x55 -> ready_o=1, count_o stays 4, and 0x55 exits 4 transfers later.
REQ-037 Bubble collapse: with ready_i=0, push 0x11, idle 2 cycles, then push 0x22 -> count_o=2 and data_o=0x11; on release, 0x11 then 0x22 come out on back-to-back cycles.
REQ-038 Flush: with 3 words held, assert flush_i for 1 cycle with valid_i=1 -> ready_o=0 and valid_o=0 that cycle, count_o=0 the next cycle, and the held words never appear.
REQ-039 Async reset: assert reset between clock edges with count_o=3 -> valid_o=0, data_o=0x00 and count_o=0 immediately; after release, the next pushed word 0x7E appears 3 cycles after its acceptance.
